// File: rtl/cmp_arb_pkg.sv
// Shared types and helpers for the round-robin comparator arbiter.
// Pure definitions; no timing or flow control of its own.
// The pick helper is sized for the largest supported requester count.
package cmp_arb_pkg;

    localparam int CMP_W   = 16;
    localparam int MAX_REQ = 8;

    typedef enum logic {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_t;

    typedef struct packed {
        logic [CMP_W-1:0] a;
        logic [CMP_W-1:0] b;
        logic             sgn;
    } op_t;

    // First set bit of valid at or above ptr, wrapping modulo nreq.
    function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                           input logic [2:0]         ptr,
                                           input int                 nreq);
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = (int'(ptr) + i) % nreq;
            if (!found && (i < nreq) && valid[idx[2:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/comp_16_bit.sv
// Unsigned 16-bit magnitude comparator producing lt/gt/eq.
// Purely combinational, zero latency.
// No flow control; operands are sampled continuously.
module comp_16_bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        lt,
    output logic        gt,
    output logic        eq
);

    assign lt = (a <  b);
    assign gt = (a >  b);
    assign eq = (a == b);

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin sharing of one 16-bit comparator among NREQ requesters.
// Latency: handshake in cycle T, registered result pulse in cycle T+2.
// Backpressure: one compare in flight; req_ready is low while busy, no response backpressure.
module cmp_arbiter
    import cmp_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*CMP_W-1:0] req_a,
    input  logic [NREQ*CMP_W-1:0] req_b,
    input  logic [NREQ-1:0]       req_signed,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_lt,
    output logic                  rsp_gt,
    output logic                  rsp_eq,
    output logic                  busy
);

    state_t           state, state_nxt;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   grant;
    logic [IDW-1:0]   ptr_nxt;
    logic             accept;
    op_t              op;
    logic [IDW-1:0]   op_id;
    logic [CMP_W-1:0] cmp_a, cmp_b;
    logic             cmp_lt, cmp_gt, cmp_eq;

    assign grant   = IDW'(rr_pick(MAX_REQ'(req_valid), 3'(rr_ptr), NREQ));
    assign ptr_nxt = (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
    assign accept  = (state == IDLE) && (|req_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // req_ready is gated by rst_n so no handshake is advertised while held in reset.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    req_ready[grant] = rst_n;
                    state_nxt        = CMP;
                end
            end
            CMP: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            op        <= '0;
            op_id     <= '0;
            rsp_valid <= '0;
            rsp_id    <= '0;
            rsp_lt    <= 1'b0;
            rsp_gt    <= 1'b0;
            rsp_eq    <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (accept) begin
                op.a   <= req_a[grant*CMP_W +: CMP_W];
                op.b   <= req_b[grant*CMP_W +: CMP_W];
                op.sgn <= req_signed[grant];
                op_id  <= grant;
                rr_ptr <= ptr_nxt;
            end
            if (state == CMP) begin
                rsp_valid[op_id] <= 1'b1;
                rsp_id           <= op_id;
                rsp_lt           <= cmp_lt;
                rsp_gt           <= cmp_gt;
                rsp_eq           <= cmp_eq;
            end
        end
    end

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    assign cmp_a = {op.a[CMP_W-1] ^ op.sgn, op.a[CMP_W-2:0]};
    assign cmp_b = {op.b[CMP_W-1] ^ op.sgn, op.b[CMP_W-2:0]};

    comp_16_bit u_cmp (
        .a  (cmp_a),
        .b  (cmp_b),
        .lt (cmp_lt),
        .gt (cmp_gt),
        .eq (cmp_eq)
    );

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed bench for cmp_arbiter with a response scoreboard.
module tb_cmp_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*16-1:0]   req_a;
    logic [NREQ*16-1:0]   req_b;
    logic [NREQ-1:0]      req_signed;
    logic [NREQ-1:0]      rsp_valid;
    logic [IDW-1:0]       rsp_id;
    logic                 rsp_lt, rsp_gt, rsp_eq, busy;

    logic [15:0]          op_a [NREQ];
    logic [15:0]          op_b [NREQ];

    typedef struct {
        logic [IDW-1:0] id;
        logic [2:0]     f;
        int             t;
    } exp_t;

    exp_t sb [$];
    int   grant_log [$];
    int   grant_tick [$];
    int   tick_n;
    bit   hold_valid;
    int   total, bad;

    always #5 clk = ~clk;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*16 +: 16] = op_a[i];
            req_b[i*16 +: 16] = op_b[i];
        end
    end

    cmp_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_signed (req_signed),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_lt     (rsp_lt),
        .rsp_gt     (rsp_gt),
        .rsp_eq     (rsp_eq),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference {lt,gt,eq} computed directly from the operand interpretation.
    function automatic logic [2:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
        if (s)
            return {$signed(a) < $signed(b), $signed(a) > $signed(b), a == b};
        return {a < b, a > b, a == b};
    endfunction

    function automatic int last_grant();
        if (grant_log.size() == 0) return -1;
        return grant_log[grant_log.size()-1];
    endfunction

    task automatic tick();
        int   g;
        exp_t e;
        @(negedge clk);
        chk("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
        g = -1;
        for (int i = 0; i < NREQ; i++)
            if (req_ready[i]) g = i;
        if (g >= 0) begin
            e.id = IDW'(g);
            e.f  = model(op_a[g], op_b[g], req_signed[g]);
            e.t  = tick_n;
            sb.push_back(e);
            grant_log.push_back(g);
            grant_tick.push_back(tick_n);
        end
        @(posedge clk);
        #1;
        tick_n++;
        if (g >= 0 && !hold_valid) req_valid[g] = 1'b0;
        if (rsp_valid != '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_valid", 32'(rsp_valid), 32'd1 << e.id);
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_flags", 32'({rsp_lt, rsp_gt, rsp_eq}), 32'(e.f));
                chk("rsp_latency", 32'(tick_n - e.t), 32'd2);
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_rsp"}, 32'({rsp_valid, rsp_id, rsp_lt, rsp_gt, rsp_eq}), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk_zero("reset");
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0; tick_n = 0; hold_valid = 1'b0;
        req_valid = '0; req_signed = '0;
        for (int i = 0; i < NREQ; i++) begin op_a[i] = '0; op_b[i] = '0; end
        repeat (2) @(posedge clk);
        #1;
        chk_zero("por");
        rst_n = 1'b1;

        // Single unsigned equal compare on requester 1.
        op_a[1] = 16'h1234; op_b[1] = 16'h1234; req_valid[1] = 1'b1;
        tick();
        chk("t1_grant", 32'(last_grant()), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_no_early_rsp", 32'(rsp_valid), 32'd0);
        tick();
        chk("t1_rsp_valid", 32'(rsp_valid), 32'b0010);
        chk("t1_flags", 32'({rsp_lt, rsp_gt, rsp_eq}), 32'b001);
        tick();
        chk("t1_pulse_end", 32'(rsp_valid), 32'd0);
        chk("t1_hold", 32'({rsp_id, rsp_lt, rsp_gt, rsp_eq}), 32'b01001);

        // All four continuously valid: rotation 0,1,2,3,0 every 2 cycles.
        do_reset();
        grant_log.delete(); grant_tick.delete();
        op_a[0] = 16'h0005; op_b[0] = 16'h0007;
        op_a[1] = 16'h9000; op_b[1] = 16'h1000;
        op_a[2] = 16'h0100; op_b[2] = 16'h0100;
        op_a[3] = 16'hFFFF; op_b[3] = 16'h0002; req_signed[3] = 1'b1;
        hold_valid = 1'b1;
        req_valid = 4'hF;
        repeat (9) tick();
        hold_valid = 1'b0;
        req_valid = '0;
        repeat (2) tick();
        chk("t2_grant_count", 32'(grant_log.size()), 32'd5);
        if (grant_log.size() == 5) begin
            for (int i = 0; i < 5; i++)
                chk("t2_grant_order", 32'(grant_log[i]), 32'(i % NREQ));
            for (int i = 0; i < 4; i++)
                chk("t2_grant_spacing", 32'(grant_tick[i+1] - grant_tick[i]), 32'd2);
        end
        req_signed = '0;

        // Sign-bit edge cases on requesters 2 and 3.
        op_a[2] = 16'h8000; op_b[2] = 16'h7FFF; req_signed[2] = 1'b1; req_valid[2] = 1'b1;
        repeat (2) tick();
        chk("t3_signed_8000", 32'({rsp_lt, rsp_gt, rsp_eq}), 32'b100);
        req_signed[2] = 1'b0; req_valid[2] = 1'b1;
        repeat (2) tick();
        chk("t3_unsigned_8000", 32'({rsp_lt, rsp_gt, rsp_eq}), 32'b010);
        op_a[3] = 16'hFFFF; op_b[3] = 16'h0001; req_signed[3] = 1'b1; req_valid[3] = 1'b1;
        repeat (2) tick();
        chk("t4_signed_ffff", 32'({rsp_id, rsp_lt, rsp_gt, rsp_eq}), 32'b11100);
        req_signed[3] = 1'b0; req_valid[3] = 1'b1;
        repeat (2) tick();
        chk("t4_unsigned_ffff", 32'({rsp_lt, rsp_gt, rsp_eq}), 32'b010);

        // Reset while a compare is in flight.
        do_reset();
        op_a[2] = 16'h0001; op_b[2] = 16'h0002; req_valid[2] = 1'b1;
        tick();
        chk("t5_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_zero("t5_midcmp");
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) begin
            tick();
            chk("t5_no_rsp", 32'(rsp_valid), 32'd0);
        end
        op_a[1] = 16'h0003; op_b[1] = 16'h0001;
        op_a[3] = 16'h0002; op_b[3] = 16'h0009;
        req_valid = 4'b1010;
        tick();
        chk("t5_grant_from_0", 32'(last_grant()), 32'd1);
        repeat (3) tick();
        chk("t5_second_grant", 32'(last_grant()), 32'd3);

        // Requester 1 withdraws while requester 0 is served.
        do_reset();
        grant_log.delete(); grant_tick.delete();
        req_valid = 4'b1011;
        tick();
        req_valid[1] = 1'b0;
        repeat (3) tick();
        chk("t6_grant_count", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() == 2) begin
            chk("t6_first", 32'(grant_log[0]), 32'd0);
            chk("t6_skip_1", 32'(grant_log[1]), 32'd3);
        end
        req_valid = '0;
        repeat (2) tick();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cmp_arbiter.md
Name: cmp_arbiter

Overview:
- Shares one 16-bit magnitude comparator (comp_16_bit) between NREQ requesters, e.g. branch unit, ALU flag path and loop counter.
- Round-robin arbitration with a valid/ready request handshake.
- Optional signed compare, implemented by an MSB flip ahead of the unsigned comparator.
- Returns registered lt/gt/eq flags tagged with the requester index.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of the response ID; equals clog2(NREQ), minimum 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester compare request.
- req_ready  output  NREQ  per-requester accept strobe; at most one bit high.
- req_a  input  NREQ*16  operand A, requester i at bits [16i+15:16i].
- req_b  input  NREQ*16  operand B, same packing as req_a.
- req_signed  input  NREQ  1 = two's-complement compare, 0 = unsigned.
- rsp_valid  output  NREQ  one-cycle result pulse to the owning requester; at most one bit high.
- rsp_id  output  IDW  index of the requester whose result is on the bus.
- rsp_lt  output  1  A < B.
- rsp_gt  output  1  A > B.
- rsp_eq  output  1  A == B.
- busy  output  1  high while a compare is in flight (state CMP).

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, rr_ptr=0.
  - Operand, ID and signed registers cleared.
  - All outputs 0: req_ready, rsp_valid, rsp_id, rsp_lt, rsp_gt, rsp_eq, busy.
- FSM states: IDLE, CMP.
- IDLE:
  - If any req_valid is high, grant g = first set bit searching from rr_ptr upward, wrapping modulo NREQ.
  - req_ready[g]=1 combinationally in this cycle; that is the handshake.
  - On the clock edge: latch req_a[g], req_b[g], req_signed[g] and g into registers; rr_ptr <= (g+1) mod NREQ; go to CMP.
  - With no request, stay in IDLE.
- CMP:
  - busy=1; req_ready all 0.
  - The comparator operates on the latched operands.
  - If signed is set, bit 15 of both operands is inverted before the comparator; no other bits change.
  - On the clock edge: register lt/gt/eq and rsp_id <= latched g; rsp_valid[g] <= 1 for exactly one cycle; go to IDLE.
- Timing:
  - Handshake accepted in cycle T; result visible in cycle T+2.
  - Throughput is one compare per 2 cycles.
  - A new grant can coincide with a rsp_valid pulse.
- Result holding:
  - rsp_lt/gt/eq/rsp_id hold their last value until the next result.
  - Exactly one of lt/gt/eq is 1 after the first result.
- Requester rules:
  - Hold req_valid and operands stable until req_ready is seen.
  - May drop req_valid before a grant; the request is then ignored.
  - Operands may change freely after the handshake.
- No response backpressure: a requester must sample rsp_valid when it is pulsed.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,NREQ-1,0.
  - Worst-case wait is NREQ grants.
- rr_ptr wraps from NREQ-1 to 0.
- Reset mid-CMP: the compare is aborted, no rsp_valid is issued, and the FSM returns to IDLE.
- Signed edge cases:
  - 0x8000 vs 0x7FFF: signed gives lt; unsigned gives gt.
  - 0xFFFF vs 0x0000: signed gives lt.

Decomposition:
- Package cmp_arb_pkg:
  - State enum {IDLE, CMP}.
  - Constant CMP_W=16.
  - Function rr_pick(valid, ptr) returning the grant index.
- Sub-module: the existing comp_16_bit, instantiated once with the MSB-flip muxing ahead of it.
- The round-robin pick stays inline; no further sub-modules.

Test Plan:
- Reset, then a single request on requester 1, unsigned, A=0x1234, B=0x1234:
  - req_ready[1] high in T; rsp_valid[1] pulsed in T+2; rsp_id=1, eq=1, lt=gt=0.
- Requesters 0..3 all valid continuously, distinct operands:
  - Grants occur in order 0,1,2,3,0 every 2 cycles.
  - Each response carries the correct id and flags.
- Requester 2, A=0x8000, B=0x7FFF:
  - signed=1 gives lt=1; repeated with signed=0 gives gt=1.
- Requester 3, A=0xFFFF, B=0x0001, signed=1:
  - lt=1 (−1 < 1); unsigned gives gt=1.
- rst_n asserted during CMP:
  - Outputs go to 0 immediately; no rsp_valid pulse follows.
  - The next request after release is granted from rr_ptr=0.
- req_valid[1] dropped before grant while requester 0 is being served:
  - No grant to requester 1.
  - rr_ptr continues to the next valid requester.
